// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined IEEE-754-style adder/subtractor.
// Unpack/align, add/normalise, round/pack; round-to-nearest-even only.
module fp_addsub_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] in_a,
    input  logic [EXP_W+FRAC_W:0] in_b,
    input  logic                  in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] out_s,
    output logic [2:0]            out_flags
);
    localparam int E  = EXP_W;
    localparam int F  = FRAC_W;
    localparam int W  = 1 + E + F;
    localparam int SH = F + 3;
    localparam int CA = $clog2(F + 5) + 1;
    localparam int CW = (E + 1 > CA) ? E + 1 : CA;

    typedef struct packed {
        logic         sgn;
        logic         sub;
        logic [E:0]   exp;
        logic [F+3:0] big;
        logic [F+3:0] sml;
        logic         nan;
        logic         inv;
        logic         inf;
        logic         isg;
    } s1_t;

    typedef struct packed {
        logic         sgn;
        logic [E:0]   exp;
        logic [F+3:0] man;
        logic         nan;
        logic         inv;
        logic         inf;
        logic         isg;
    } s2_t;

    logic         adv;
    logic         v1_q, v2_q, v3_q;
    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic [W-1:0] res_d, res_q;
    logic [2:0]   flg_d, flg_q;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_s     = res_q;
    assign out_flags = flg_q;

    logic           sa, sb, nan_a, nan_b, inf_a, inf_b, a_big;
    logic [E-1:0]   ea, eb, xa, xb;
    logic [F:0]     ma, mb, mbig, msml;
    logic [CW-1:0]  dexp;
    logic [2*F+5:0] aln;

    // unpack, classify specials, order by magnitude, align the smaller
    always_comb begin
        sa    = in_a[W-1];
        sb    = in_b[W-1] ^ in_op;
        ea    = in_a[W-2:F];
        eb    = in_b[W-2:F];
        xa    = (ea == '0) ? E'(1) : ea;
        xb    = (eb == '0) ? E'(1) : eb;
        ma    = {ea != '0, in_a[F-1:0]};
        mb    = {eb != '0, in_b[F-1:0]};
        nan_a = (&ea) && (in_a[F-1:0] != '0);
        nan_b = (&eb) && (in_b[F-1:0] != '0);
        inf_a = (&ea) && (in_a[F-1:0] == '0);
        inf_b = (&eb) && (in_b[F-1:0] == '0);
        a_big = in_a[W-2:0] >= in_b[W-2:0];
        mbig  = a_big ? ma : mb;
        msml  = a_big ? mb : ma;
        dexp  = a_big ? CW'(xa) - CW'(xb) : CW'(xb) - CW'(xa);
        if (dexp > CW'(SH))
            dexp = CW'(SH);
        aln   = {msml, 2'b00, {(F+3){1'b0}}} >> dexp;
        s1_d.sgn = a_big ? sa : sb;
        s1_d.sub = sa ^ sb;
        s1_d.exp = {1'b0, a_big ? xa : xb};
        s1_d.big = {mbig, 3'b000};
        s1_d.sml = {aln[2*F+5:F+3], |aln[F+2:0]};
        s1_d.nan = nan_a | nan_b;
        s1_d.inv = !s1_d.nan && inf_a && inf_b && s1_d.sub;
        s1_d.inf = !s1_d.nan && !s1_d.inv && (inf_a | inf_b);
        s1_d.isg = inf_a ? sa : sb;
    end

    logic [F+4:0]  sum;
    logic [F+3:0]  nrm;
    logic [CW-1:0] lz, lim, shl;

    function automatic logic [CW-1:0] lzc(input logic [F+3:0] x);
        logic [CW-1:0] n;
        n = CW'(F + 4);
        for (int i = 0; i <= F + 3; i++)
            if (x[i])
                n = CW'(F + 3 - i);
        return n;
    endfunction

    // add/subtract magnitudes, normalise without going below exponent 1
    always_comb begin
        sum = s1_q.sub ? {1'b0, s1_q.big} - {1'b0, s1_q.sml}
                       : {1'b0, s1_q.big} + {1'b0, s1_q.sml};
        lz  = lzc(sum[F+3:0]);
        lim = CW'(s1_q.exp) - CW'(1);
        shl = (lz < lim) ? lz : lim;
        nrm = sum[F+3:0] << shl;
        s2_d.exp = s1_q.exp - (E+1)'(shl);
        if (sum[F+4]) begin
            nrm      = {sum[F+4:2], sum[1] | sum[0]};
            s2_d.exp = s1_q.exp + (E+1)'(1);
        end
        s2_d.sgn = (s1_q.sub && sum == '0) ? 1'b0 : s1_q.sgn;
        s2_d.man = nrm;
        s2_d.nan = s1_q.nan;
        s2_d.inv = s1_q.inv;
        s2_d.inf = s1_q.inf;
        s2_d.isg = s1_q.isg;
    end

    logic [F:0]   m3;
    logic         g3, r3, t3, rup, hid, ovf;
    logic [F+1:0] mr;
    logic [E:0]   eo;
    logic [F-1:0] fr;

    // round to nearest even, pack, then apply overflow and special cases
    always_comb begin
        m3  = s2_q.man[F+3:3];
        g3  = s2_q.man[2];
        r3  = s2_q.man[1];
        t3  = s2_q.man[0];
        rup = g3 & (r3 | t3 | m3[0]);
        mr  = {1'b0, m3} + (F+2)'(rup);
        hid = mr[F+1] | mr[F];
        eo  = s2_q.exp + (E+1)'(mr[F+1]);
        fr  = mr[F+1] ? mr[F:1] : mr[F-1:0];
        ovf = hid && (eo >= {1'b0, {E{1'b1}}});
        res_d = {s2_q.sgn, hid ? eo[E-1:0] : {E{1'b0}}, fr};
        flg_d = {2'b00, g3 | r3 | t3};
        if (ovf) begin
            res_d = {s2_q.sgn, {E{1'b1}}, {F{1'b0}}};
            flg_d = 3'b011;
        end
        if (s2_q.nan || s2_q.inv) begin
            res_d = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
            flg_d = {s2_q.inv, 2'b00};
        end else if (s2_q.inf) begin
            res_d = {s2_q.isg, {E{1'b1}}, {F{1'b0}}};
            flg_d = 3'b000;
        end
    end

    // pipeline registers; all stages move only when the output can drain
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else if (adv) begin
            v1_q  <= in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and random operands for fp_addsub_pipe,
// scored against an exact wide-integer model of single-precision add.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic [2:0]  out_flags;

    fp_addsub_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_pop = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    // exact reference: operands as integers in units of 2^-149
    function automatic logic [34:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic op);
        logic         sa, sb, na, nb, ia, ib, sr, up;
        logic [7:0]   ea, eb;
        logic [299:0] ma, mb, mag, mant, rem, half, one;
        int           p, sh, xa, xb;
        sa = a[31];
        sb = b[31] ^ op;
        ea = a[30:23];
        eb = b[30:23];
        na = (ea == 8'hFF) && (a[22:0] != 23'h0);
        nb = (eb == 8'hFF) && (b[22:0] != 23'h0);
        ia = (ea == 8'hFF) && (a[22:0] == 23'h0);
        ib = (eb == 8'hFF) && (b[22:0] == 23'h0);
        if (na || nb) return {3'b000, 32'h7FC00000};
        if (ia && ib && (sa != sb)) return {3'b100, 32'h7FC00000};
        if (ia) return {3'b000, sa, 8'hFF, 23'h0};
        if (ib) return {3'b000, sb, 8'hFF, 23'h0};
        xa = (ea == 8'h0) ? 1 : int'(ea);
        xb = (eb == 8'h0) ? 1 : int'(eb);
        one = 300'(1);
        ma = 300'({ea != 8'h0, a[22:0]}) << (xa - 1);
        mb = 300'({eb != 8'h0, b[22:0]}) << (xb - 1);
        if (sa == sb) begin
            mag = ma + mb;
            sr  = sa;
        end else if (ma >= mb) begin
            mag = ma - mb;
            sr  = sa;
        end else begin
            mag = mb - ma;
            sr  = sb;
        end
        if (mag == 300'(0)) sr = (sa == sb) ? sa : 1'b0;
        p = -1;
        for (int i = 0; i < 300; i++)
            if (mag[i]) p = i;
        if (p <= 23) return {3'b000, sr, 7'b0, mag[23], mag[22:0]};
        sh   = p - 23;
        mant = mag >> sh;
        rem  = mag & ((one << sh) - one);
        half = one << (sh - 1);
        up   = (rem > half) || ((rem == half) && mant[0]);
        mant = mant + 300'(up);
        if (mant[24]) begin
            mant = mant >> 1;
            sh++;
        end
        if (sh + 1 >= 255) return {3'b011, sr, 8'hFF, 23'h0};
        return {2'b00, rem != 300'(0), sr, 8'(sh + 1), mant[22:0]};
    endfunction

    logic [34:0] exp_q[$];
    int          cyc_q[$];
    logic        held = 1'b0;
    logic        chk_lat = 1'b0;
    logic [34:0] held_v;
    logic [34:0] m_e;
    int          m_c;

    // scoreboard: push model on input transfer, compare on output transfer
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cyc_q.delete();
            held = 1'b0;
        end else begin
            if (held)
                chk("hold", {28'b0, out_valid, out_flags, out_s},
                    {28'b0, 1'b1, held_v});
            held = 1'b0;
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected: got %h, want none",
                             {out_flags, out_s});
                end else begin
                    m_e = exp_q.pop_front();
                    m_c = cyc_q.pop_front();
                    chk("result", {29'b0, out_flags, out_s}, {29'b0, m_e});
                    if (chk_lat)
                        chk("latency", 64'(cyc - m_c), 64'd3);
                end
            end else if (out_valid) begin
                held   = 1'b1;
                held_v = {out_flags, out_s};
            end
            if (in_valid && in_ready) begin
                n_push++;
                exp_q.push_back(model(in_a, in_b, in_op));
                cyc_q.push_back(cyc);
            end
        end
    end

    logic rnd_rdy = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    logic [31:0] va[16];
    logic [31:0] vb[16];
    logic        vo[16];
    logic [34:0] ve[16];

    task automatic setv(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [2:0] f,
                        input logic [31:0] s);
        va[i] = a;
        vb[i] = b;
        vo[i] = op;
        ve[i] = {f, s};
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic op);
        logic acc;
        int   t;
        t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 60);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        for (int k = 0; k < lim && exp_q.size() != 0; k++)
            @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int          idx, p0;
    logic        acc;
    logic [31:0] ra, rb;
    int          md;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = 1'b0;
        out_ready = 1'b1;
        setv(0,  32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 32'h40000000);
        setv(1,  32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 32'h00000000);
        setv(2,  32'h3F800000, 32'h33800000, 1'b0, 3'b001, 32'h3F800000);
        setv(3,  32'h3F800000, 32'h34400000, 1'b0, 3'b001, 32'h3F800002);
        setv(4,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b011, 32'h7F800000);
        setv(5,  32'h7F800000, 32'hFF800000, 1'b0, 3'b100, 32'h7FC00000);
        setv(6,  32'h7FC00001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000);
        setv(7,  32'h00000001, 32'h00000001, 1'b0, 3'b000, 32'h00000002);
        setv(8,  32'h00800000, 32'h00000001, 1'b1, 3'b000, 32'h007FFFFF);
        setv(9,  32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h80000000);
        setv(10, 32'h40400000, 32'h3F800000, 1'b1, 3'b000, 32'h40000000);
        setv(11, 32'hBF800000, 32'h3F000000, 1'b0, 3'b000, 32'hBF000000);
        setv(12, 32'h7F800000, 32'h3F800000, 1'b0, 3'b000, 32'h7F800000);
        setv(13, 32'h3F800000, 32'h3F800001, 1'b1, 3'b000, 32'hB4000000);
        setv(14, 32'hFF800000, 32'hFF800000, 1'b1, 3'b100, 32'h7FC00000);
        setv(15, 32'h00000000, 32'h00000000, 1'b1, 3'b000, 32'h00000000);

        for (int i = 0; i < 16; i++)
            chk($sformatf("model%0d", i), 64'(model(va[i], vb[i], vo[i])),
                64'(ve[i]));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(out_s), 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // directed stream at full throughput
        chk_lat = 1'b1;
        p0 = n_pop;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            in_op = vo[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain(20);
        chk("dir_count", 64'(n_pop - p0), 64'd16);

        // back-pressure: fill with out_ready low, then toggle it
        chk_lat = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        p0 = n_pop;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_a = va[idx + 2];
            in_b = vb[idx + 2];
            in_op = vo[idx + 2];
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 60 && (idx < 5 || exp_q.size() != 0); k++) begin
            out_ready = k[0];
            in_valid = (idx < 5);
            if (idx < 5) begin
                in_a = va[idx + 2];
                in_b = vb[idx + 2];
                in_op = vo[idx + 2];
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", 64'(idx), 64'd5);
        chk("bp_delivered", 64'(n_pop - p0), 64'd5);

        // reset with three operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(va[k + 9], vb[k + 9], vo[k + 9]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_s", 64'(out_s), 64'd0);
        chk("mid_rst_flags", 64'(out_flags), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        p0 = n_pop;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send(va[13], vb[13], vo[13]);
        drain(10);
        chk("post_rst_count", 64'(n_pop - p0), 64'd1);

        // random operands under random back-pressure
        chk_lat = 1'b0;
        rnd_rdy = 1'b1;
        p0 = n_pop;
        for (int k = 0; k < 300; k++) begin
            ra = $urandom;
            rb = $urandom;
            md = $urandom_range(0, 3);
            if (md == 1) begin
                rb[30:23] = ra[30:23] - 8'($urandom_range(0, 2));
            end else if (md == 2) begin
                rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
            end else if (md == 3) begin
                ra[30:23] = 8'($urandom_range(0, 2));
                rb[30:23] = 8'($urandom_range(0, 2));
            end
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        rnd_rdy = 1'b0;
        #3;
        out_ready = 1'b1;
        drain(40);
        chk("rnd_count", 64'(n_pop - p0), 64'd300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
